// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS configuration sequencer.
package dds_pkg;

  // Field widths fixed by the byte-wide register map.
  localparam int CFG_FRE_W   = 24;
  localparam int CFG_AMP_W   = 16;
  localparam int CFG_DWELL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_SWEEP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] ADDR_WAVE   = 4'd0;
  localparam logic [3:0] ADDR_FREQ0  = 4'd1;
  localparam logic [3:0] ADDR_FREQ1  = 4'd2;
  localparam logic [3:0] ADDR_FREQ2  = 4'd3;
  localparam logic [3:0] ADDR_AMP0   = 4'd4;
  localparam logic [3:0] ADDR_AMP1   = 4'd5;
  localparam logic [3:0] ADDR_STEP0  = 4'd6;
  localparam logic [3:0] ADDR_STEP1  = 4'd7;
  localparam logic [3:0] ADDR_STEP2  = 4'd8;
  localparam logic [3:0] ADDR_STOP0  = 4'd9;
  localparam logic [3:0] ADDR_STOP1  = 4'd10;
  localparam logic [3:0] ADDR_STOP2  = 4'd11;
  localparam logic [3:0] ADDR_DWELL0 = 4'd12;
  localparam logic [3:0] ADDR_DWELL1 = 4'd13;
  localparam logic [3:0] ADDR_CTRL   = 4'd14;

  localparam int CTRL_SWEEP_EN = 0;
  localparam int CTRL_LOOP     = 1;

  localparam logic [7:0] WAVE_SIN = 8'd1;
  localparam logic [7:0] WAVE_SQU = 8'd2;
  localparam logic [7:0] WAVE_TRI = 8'd3;

  typedef struct packed {
    logic [7:0]             wave;
    logic [CFG_FRE_W-1:0]   freq_start;
    logic [CFG_AMP_W-1:0]   amp;
    logic [CFG_FRE_W-1:0]   step;
    logic [CFG_FRE_W-1:0]   stop;
    logic [CFG_DWELL_W-1:0] dwell;
    logic                   sweep_en;
    logic                   loop_en;
  } cfg_t;

  // Merge one register byte into a config image; unmapped addresses leave it untouched.
  function automatic cfg_t cfg_write(input cfg_t c, input logic [3:0] a, input logic [7:0] d);
    cfg_t r;
    r = c;
    case (a)
      ADDR_WAVE:   r.wave              = d;
      ADDR_FREQ0:  r.freq_start[7:0]   = d;
      ADDR_FREQ1:  r.freq_start[15:8]  = d;
      ADDR_FREQ2:  r.freq_start[23:16] = d;
      ADDR_AMP0:   r.amp[7:0]          = d;
      ADDR_AMP1:   r.amp[15:8]         = d;
      ADDR_STEP0:  r.step[7:0]         = d;
      ADDR_STEP1:  r.step[15:8]        = d;
      ADDR_STEP2:  r.step[23:16]       = d;
      ADDR_STOP0:  r.stop[7:0]         = d;
      ADDR_STOP1:  r.stop[15:8]        = d;
      ADDR_STOP2:  r.stop[23:16]       = d;
      ADDR_DWELL0: r.dwell[7:0]        = d;
      ADDR_DWELL1: r.dwell[15:8]       = d;
      ADDR_CTRL: begin
        r.sweep_en = d[CTRL_SWEEP_EN];
        r.loop_en  = d[CTRL_LOOP];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dds_cfg_regs.sv
// Shadow register bank plus the pending snapshot taken on commit.
module dds_cfg_regs
  import dds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output cfg_t       pend
);

  cfg_t shadow;
  cfg_t shadow_nxt;

  // Fold this cycle's write in first so a same-cycle commit captures it.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) shadow_nxt = cfg_write(shadow, wr_addr, wr_data);
  end

  // Shadow follows writes in every state; pending only moves on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      pend   <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (commit) pend <= shadow_nxt;
    end
  end

endmodule

// File: rtl/dds_cfg_sequencer.sv
// Applies committed DDS settings on a phase wrap and runs optional frequency sweeps.
//
// state | meaning
// IDLE  | nothing applied since reset
// ARM   | snapshot pending, waiting for wrap / timeout (or dds_en==0)
// RUN   | static config applied
// SWEEP | stepping fre_dat toward STOP
// DONE  | sweep finished, holding STOP
module dds_cfg_sequencer
  import dds_pkg::*;
#(
  parameter int FRE_W        = 24,
  parameter int AMP_W        = 16,
  parameter int DWELL_W      = 16,
  parameter int SYNC_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  input  logic             phase_wrap,
  output logic [7:0]       pic_dat,
  output logic [FRE_W-1:0] fre_dat,
  output logic [AMP_W-1:0] amp_dat,
  output logic             dds_en,
  output logic             busy,
  output logic             sweep_done
);

  localparam int TMR_W = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;

  cfg_t               pend;
  state_t             state;
  logic [TMR_W-1:0]   sync_tmr;
  logic               apply_req;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [FRE_W-1:0]   act_start;
  logic [FRE_W-1:0]   act_step;
  logic [FRE_W-1:0]   act_stop;
  logic [DWELL_W-1:0] act_dwell;
  logic               act_loop;
  logic               sweep_live;

  logic               sync_hit;
  logic               apply_now;
  logic               act_degen;
  logic               pend_degen;
  logic [FRE_W:0]     step_sum;
  logic [FRE_W-1:0]   step_fre;
  logic               step_fin;

  dds_cfg_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .commit  (commit),
    .pend    (pend)
  );

  // A DDS that is not yet running has no phase to protect, so apply at once.
  assign sync_hit   = !dds_en || phase_wrap || (sync_tmr == TMR_W'(SYNC_TIMEOUT - 1));
  assign apply_now  = (state == ST_ARM) && apply_req && !commit;
  assign act_degen  = (act_step == '0) || (act_start >= act_stop);
  assign pend_degen = (pend.step == '0) || (pend.freq_start >= pend.stop);

  // Each frequency is held max(DWELL,1) cycles; reload value is one less.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // Next sweep frequency at dwell expiry; the extra sum bit catches overflow past 2^FRE_W.
  always_comb begin
    step_sum = {1'b0, fre_dat} + {1'b0, act_step};
    step_fre = fre_dat;
    step_fin = 1'b0;
    if (act_degen) begin
      step_fre = act_start;
      step_fin = ~act_loop;
    end else if (fre_dat == act_stop) begin
      step_fre = act_loop ? act_start : act_stop;
      step_fin = ~act_loop;
    end else if (step_sum > {1'b0, act_stop}) begin
      step_fre = act_stop;
      step_fin = ~act_loop;
    end else begin
      step_fre = step_sum[FRE_W-1:0];
    end
  end

  // Sequencer: sweep stepping keeps going in ARM until the new config lands; commit wins over DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pic_dat    <= '0;
      fre_dat    <= '0;
      amp_dat    <= '0;
      dds_en     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      sync_tmr   <= '0;
      apply_req  <= 1'b0;
      dwell_cnt  <= '0;
      act_start  <= '0;
      act_step   <= '0;
      act_stop   <= '0;
      act_dwell  <= '0;
      act_loop   <= 1'b0;
      sweep_live <= 1'b0;
    end else begin
      if (sweep_live && !apply_now) begin
        if (dwell_cnt == '0) begin
          fre_dat   <= step_fre;
          dwell_cnt <= dwell_load(act_dwell);
          if (step_fin) begin
            sweep_live <= 1'b0;
            if (state == ST_SWEEP) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
            end
          end
        end else begin
          dwell_cnt <= dwell_cnt - 1'b1;
        end
      end

      case (state)
        ST_IDLE, ST_RUN, ST_DONE, ST_SWEEP: begin
          if (commit) begin
            state      <= ST_ARM;
            busy       <= 1'b1;
            sweep_done <= 1'b0;
            sync_tmr   <= '0;
            apply_req  <= 1'b0;
          end
        end
        ST_ARM: begin
          if (commit) begin
            sync_tmr  <= '0;
            apply_req <= 1'b0;
          end else if (apply_req) begin
            apply_req <= 1'b0;
            pic_dat   <= pend.wave;
            fre_dat   <= FRE_W'(pend.freq_start);
            amp_dat   <= AMP_W'(pend.amp);
            dds_en    <= 1'b1;
            act_start <= FRE_W'(pend.freq_start);
            act_step  <= FRE_W'(pend.step);
            act_stop  <= FRE_W'(pend.stop);
            act_dwell <= DWELL_W'(pend.dwell);
            act_loop  <= pend.loop_en;
            dwell_cnt <= dwell_load(DWELL_W'(pend.dwell));
            if (!pend.sweep_en) begin
              state      <= ST_RUN;
              busy       <= 1'b0;
              sweep_live <= 1'b0;
            end else if (pend_degen && !pend.loop_en) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
              sweep_live <= 1'b0;
            end else begin
              state      <= ST_SWEEP;
              sweep_live <= 1'b1;
            end
          end else begin
            sync_tmr <= sync_tmr + 1'b1;
            if (sync_hit) apply_req <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cfg_sequencer.sv
// Randomized bench for dds_cfg_sequencer with a spec-level reference model.
module tb_dds_cfg_sequencer;
  import dds_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, wr_en, commit, phase_wrap;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  pic_dat;
  logic [23:0] fre_dat;
  logic [15:0] amp_dat;
  logic        dds_en, busy, sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: register bytes as written, bytes captured at commit, and what is on the outputs.
  logic [7:0]  sh   [16];
  logic [7:0]  pend [16];
  logic        m_en;
  logic [23:0] a_fre;
  logic [23:0] exp_fre  [64];
  bit          exp_done [64];

  dds_cfg_sequencer #(
    .FRE_W(24), .AMP_W(16), .DWELL_W(16), .SYNC_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .phase_wrap (phase_wrap),
    .pic_dat    (pic_dat),
    .fre_dat    (fre_dat),
    .amp_dat    (amp_dat),
    .dds_en     (dds_en),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] p24(input int b);
    return {pend[b+2], pend[b+1], pend[b]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      sh[i]   = 8'h00;
      pend[i] = 8'h00;
    end
    m_en  = 1'b0;
    a_fre = 24'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a != 4'd15) sh[a] = d;
  endtask

  task automatic do_commit(input bit with_wr, input logic [3:0] a, input logic [7:0] d);
    wr_en = with_wr; wr_addr = a; wr_data = d; commit = 1'b1;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    if (with_wr && a != 4'd15) sh[a] = d;
    for (int i = 0; i < 16; i++) pend[i] = sh[i];
    chk("commit_busy", 32'(busy), 32'd1);
  endtask

  // Static config apply: lands one edge after the first ARM cycle meeting the sync rule.
  task automatic run_arm(input int wrap_at);
    int cond;
    int ap;
    if (!m_en) cond = 1;
    else if (wrap_at > 0 && wrap_at < TMO) cond = wrap_at;
    else cond = TMO;
    ap = cond + 1;
    for (int e = 1; e <= ap; e++) begin
      phase_wrap = (e == wrap_at);
      tick();
      phase_wrap = 1'b0;
      if (e < ap) begin
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_hold_fre", 32'(fre_dat), 32'(a_fre));
      end
    end
    a_fre = p24(1);
    m_en  = 1'b1;
    chk("apply_pic", 32'(pic_dat), 32'(pend[0]));
    chk("apply_fre", 32'(fre_dat), 32'(a_fre));
    chk("apply_amp", 32'(amp_dat), 32'({pend[5], pend[4]}));
    chk("apply_en", 32'(dds_en), 32'd1);
    chk("apply_busy", 32'(busy), 32'd0);
    chk("apply_done", 32'(sweep_done), 32'd0);
  endtask

  // Expected fre_dat / sweep_done per cycle, index 0 = the apply edge.
  task automatic build_trace(input logic [23:0] s, input logic [23:0] st, input logic [23:0] sp,
                             input int dw, input bit lp, input int n);
    int     d;
    int     t;
    longint v;
    longint nx;
    bit     fin;
    d = (dw == 0) ? 1 : dw;
    t = 0;
    v = longint'(s);
    fin = 1'b0;
    if (st == 24'h0 || s >= sp) begin
      for (int i = 0; i < n; i++) begin
        exp_fre[i]  = s;
        exp_done[i] = !lp;
      end
      return;
    end
    while (t < n) begin
      for (int k = 0; k < d && t < n; k++) begin
        exp_fre[t]  = 24'(v);
        exp_done[t] = 1'b0;
        t++;
      end
      if (v == longint'(sp)) begin
        if (lp) v = longint'(s);
        else fin = 1'b1;
      end else begin
        nx = v + longint'(st);
        if (nx > longint'(sp)) begin
          v = longint'(sp);
          if (!lp) fin = 1'b1;
        end else begin
          v = nx;
        end
      end
      if (fin) begin
        while (t < n) begin
          exp_fre[t]  = sp;
          exp_done[t] = 1'b1;
          t++;
        end
      end
    end
  endtask

  // Reset (possibly mid-sweep), program a sweep, commit, then follow it cycle by cycle.
  task automatic run_sweep(input logic [23:0] s, input logic [23:0] st, input logic [23:0] sp,
                           input logic [15:0] dw, input bit lp, input int n);
    logic [7:0] b [16];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fre", 32'(fre_dat), 32'd0);
    chk("rst_pic", 32'(pic_dat), 32'd0);
    chk("rst_en", 32'(dds_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    model_reset();
    b[0]  = 8'($urandom_range(1, 3));
    b[1]  = s[7:0];   b[2]  = s[15:8];  b[3]  = s[23:16];
    b[4]  = 8'($urandom); b[5] = 8'($urandom);
    b[6]  = st[7:0];  b[7]  = st[15:8]; b[8]  = st[23:16];
    b[9]  = sp[7:0];  b[10] = sp[15:8]; b[11] = sp[23:16];
    b[12] = dw[7:0];  b[13] = dw[15:8];
    b[14] = {6'd0, lp, 1'b1};
    b[15] = 8'($urandom);
    for (int a = 0; a < 16; a++) wr(4'(a), b[a]);
    do_commit(1'b0, 4'd0, 8'd0);
    tick();
    chk("sw_e1_en", 32'(dds_en), 32'd0);
    tick();
    chk("sw_pic", 32'(pic_dat), 32'(pend[0]));
    chk("sw_amp", 32'(amp_dat), 32'({pend[5], pend[4]}));
    chk("sw_en", 32'(dds_en), 32'd1);
    build_trace(s, st, sp, int'(dw), lp, n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      chk("sw_fre", 32'(fre_dat), 32'(exp_fre[i]));
      chk("sw_done", 32'(sweep_done), 32'(exp_done[i]));
      chk("sw_busy", 32'(busy), 32'(!exp_done[i]));
    end
  endtask

  initial begin
    logic [23:0] s, st, sp;
    logic [15:0] dw;
    rst = 1'b1; wr_en = 1'b0; commit = 1'b0; phase_wrap = 1'b0;
    wr_addr = 4'd0; wr_data = 8'd0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_pic", 32'(pic_dat), 32'd0);
    chk("reset_fre", 32'(fre_dat), 32'd0);
    chk("reset_amp", 32'(amp_dat), 32'd0);
    chk("reset_en", 32'(dds_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(sweep_done), 32'd0);

    // First apply from reset: two edges after the commit edge.
    wr(ADDR_WAVE, WAVE_SIN);
    wr(ADDR_FREQ0, 8'h00); wr(ADDR_FREQ1, 8'h10); wr(ADDR_FREQ2, 8'h00);
    wr(ADDR_AMP0, 8'h00);  wr(ADDR_AMP1, 8'h80);
    do_commit(1'b0, 4'd0, 8'd0);
    tick();
    chk("first_e1_en", 32'(dds_en), 32'd0);
    chk("first_e1_fre", 32'(fre_dat), 32'd0);
    tick();
    chk("first_e2_en", 32'(dds_en), 32'd1);
    chk("first_e2_fre", 32'(fre_dat), 32'h001000);
    chk("first_e2_pic", 32'(pic_dat), 32'(WAVE_SIN));
    chk("first_e2_amp", 32'(amp_dat), 32'h8000);
    chk("first_e2_busy", 32'(busy), 32'd0);
    m_en = 1'b1;
    a_fre = 24'h001000;

    // Phase-synchronised apply.
    wr(ADDR_FREQ1, 8'h20);
    chk("write_no_effect", 32'(fre_dat), 32'h001000);
    do_commit(1'b0, 4'd0, 8'd0);
    run_arm(10);
    chk("sync_fre", 32'(fre_dat), 32'h002000);

    // Forced apply after the sync timeout.
    wr(ADDR_FREQ1, 8'h30);
    do_commit(1'b0, 4'd0, 8'd0);
    run_arm(0);
    chk("timeout_fre", 32'(fre_dat), 32'h003000);

    // Write in the commit cycle is part of the snapshot.
    do_commit(1'b1, ADDR_WAVE, WAVE_TRI);
    run_arm(4);
    chk("same_cycle_wave", 32'(pic_dat), 32'(WAVE_TRI));

    // Second commit in ARM restarts the timer; only the later snapshot is applied.
    wr(ADDR_FREQ1, 8'hAA);
    do_commit(1'b0, 4'd0, 8'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_hold", 32'(fre_dat), 32'(a_fre));
    end
    do_commit(1'b1, ADDR_FREQ0, 8'h55);
    run_arm(0);
    chk("restart_fre", 32'(fre_dat), 32'h00AA55);

    // Random static configs with random wrap timing (some beyond the timeout).
    for (int r = 0; r < 20; r++) begin
      wr(ADDR_WAVE, 8'($urandom));
      wr(ADDR_FREQ0, 8'($urandom)); wr(ADDR_FREQ1, 8'($urandom)); wr(ADDR_FREQ2, 8'($urandom));
      wr(ADDR_AMP0, 8'($urandom));  wr(ADDR_AMP1, 8'($urandom));
      if ($urandom_range(0, 1) == 1)
        do_commit(1'b1, 4'($urandom_range(0, 5)), 8'($urandom));
      else
        do_commit(1'b0, 4'd0, 8'd0);
      run_arm(int'($urandom_range(0, 20)));
    end

    // Directed sweeps: exact stop, then overflow with loop.
    run_sweep(24'd1000, 24'd500, 24'd2000, 16'd3, 1'b0, 16);
    run_sweep(24'hFFFF00, 24'h000200, 24'hFFFFFF, 16'd2, 1'b1, 14);

    // Random sweeps; each begins with a reset taken mid-run.
    for (int r = 0; r < 12; r++) begin
      s = 24'($urandom);
      if ($urandom_range(0, 1) == 1) s = 24'hFFF000 | 24'($urandom_range(0, 4095));
      st = 24'($urandom_range(0, 400));
      sp = s + 24'($urandom_range(0, 1500));
      if ($urandom_range(0, 3) == 0) sp = 24'hFFFFFF;
      dw = 16'($urandom_range(0, 4));
      run_sweep(s, st, sp, dw, 1'($urandom_range(0, 1)), 40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
